// File: rtl/nrisc_pkg.sv
// Shared encodings for the nRisc sequencer: opcodes, ALU operation codes and FSM states.
package nrisc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_LI   = 3'b100;
  localparam logic [2:0] OP_BGZ  = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_IMM   = 2'b10;
  localparam logic [1:0] ALU_PASSA = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StDone   = 3'd6
  } state_e;

  // Loads/stores pass A through as the address; BGZ passes A so alu_gz reflects the register.
  function automatic logic [1:0] aluOpFor(input logic [2:0] op);
    logic [1:0] code;
    case (op)
      OP_SUB:               code = ALU_SUB;
      OP_LI:                code = ALU_IMM;
      OP_LW, OP_SW, OP_BGZ: code = ALU_PASSA;
      default:              code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/nrisc_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the 8-bit nRisc datapath,
// with a data-memory wait counter and a saturating retire counter acting as a watchdog.
module nrisc_seq_ctrl
  import nrisc_pkg::*;
#(
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MAX_INSTR = 200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       imem_ack,
  input  logic       alu_gz,
  output logic       imem_req,
  output logic       ir_load,
  output logic       pc_clear,
  output logic       pc_inc,
  output logic       pc_branch,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       reg_src,
  output logic       mem_re,
  output logic       mem_we,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] retired
);

  localparam logic [2:0] LastWait = 3'(MEM_LAT - 1);
  localparam logic [7:0] MaxRet   = 8'(MAX_INSTR);

  state_e     stateQ, stateD;
  logic [2:0] opQ, opD;
  logic [2:0] waitQ, waitD;
  logic [7:0] retiredQ, retiredD;
  logic       errQ, errD;

  // Operand/offset bits belong to the datapath.
  logic unusedInstrBits;
  assign unusedInstrBits = ^instr[4:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stateQ   <= StIdle;
      opQ      <= 3'd0;
      waitQ    <= 3'd0;
      retiredQ <= 8'd0;
      errQ     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      opQ      <= opD;
      waitQ    <= waitD;
      retiredQ <= retiredD;
      errQ     <= errD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    opD       = opQ;
    waitD     = waitQ;
    retiredD  = retiredQ;
    errD      = errQ;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    pc_clear  = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    alu_op    = ALU_ADD;
    reg_we    = 1'b0;
    reg_src   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    busy      = (stateQ != StIdle) && (stateQ != StDone);
    done      = (stateQ == StDone);
    err       = errQ;
    retired   = retiredQ;

    unique case (stateQ)
      StIdle, StDone: begin
        if (start) begin
          pc_clear = 1'b1;
          retiredD = 8'd0;
          errD     = 1'b0;
          stateD   = StFetch;
        end
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          opD     = instr[7:5];
          stateD  = StDecode;
        end
      end
      StDecode: stateD = StExec;
      StExec: begin
        alu_op = aluOpFor(opQ);
        case (opQ)
          OP_ADD, OP_SUB, OP_LI: stateD = StWb;
          OP_LW, OP_SW: begin
            waitD  = 3'd0;
            stateD = StMem;
          end
          OP_BGZ: begin
            pc_branch = alu_gz;
            pc_inc    = ~alu_gz;
            stateD    = StFetch;
          end
          OP_J: begin
            pc_branch = 1'b1;
            stateD    = StFetch;
          end
          default: stateD = StDone;
        endcase
      end
      StMem: begin
        mem_re = (opQ == OP_LW);
        mem_we = (opQ == OP_SW);
        if (waitQ == LastWait) begin
          if (opQ == OP_LW) begin
            stateD = StWb;
          end else begin
            pc_inc = 1'b1;
            stateD = StFetch;
          end
        end else begin
          waitD = 3'(waitQ + 3'd1);
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        reg_src = (opQ == OP_LW);
        pc_inc  = 1'b1;
        stateD  = StFetch;
      end
      default: stateD = StIdle;
    endcase

    // The retiring strobe still goes out; the watchdog only redirects the next state.
    if (pc_inc || pc_branch) begin
      if (retiredQ != 8'hFF) begin
        retiredD = retiredQ + 8'd1;
      end
      if (({1'b0, retiredQ} + 9'd1) >= {1'b0, MaxRet}) begin
        stateD = StDone;
        errD   = 1'b1;
      end
    end
  end

endmodule
